// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and transfer encoding for the fetch-to-decode prefetch queue.
package inst_fetch_queue_pkg;

  localparam logic              RstEnable  = 1'b1;
  localparam logic [31:0]       Zero       = 32'h0;
  localparam int unsigned       QueueDepth = 4;
  localparam logic              Valid      = 1'b1;
  localparam logic              Invalid    = 1'b0;

  typedef enum logic [1:0] {
    XferNone = 2'b00,
    XferPush = 2'b01,
    XferPop  = 2'b10,
    XferBoth = 2'b11
  } xfer_e;

  function automatic xfer_e xfer_kind(input logic push, input logic pop);
    return xfer_e'({pop, push});
  endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Circular prefetch FIFO of {pc, inst} pairs between fetch and decode,
// with single-cycle flush of wrong-path entries on a taken branch.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = QueueDepth,
  parameter  int unsigned AW    = 32,
  parameter  int unsigned DW    = 32,
  localparam int unsigned PTRW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [AW-1:0]   in_pc,
  input  logic [DW-1:0]   in_inst,
  output logic            in_ready,
  input  logic            flush,
  output logic            out_valid,
  output logic [AW-1:0]   out_pc,
  output logic [DW-1:0]   out_inst,
  input  logic            out_ready,
  output logic [PTRW:0]   count
);

  localparam logic [PTRW:0] CountFull = (PTRW + 1)'(DEPTH);

  logic [AW-1:0]   pc_mem_q   [DEPTH];
  logic [DW-1:0]   inst_mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW:0]   count_q,  count_d;
  logic            push, pop;

  // Ready/valid depend only on registered occupancy, never on out_ready.
  assign in_ready  = (count_q != CountFull) ? Valid : Invalid;
  assign out_valid = (count_q != '0)        ? Valid : Invalid;
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]   : AW'(Zero);
  assign out_inst  = out_valid ? inst_mem_q[rd_ptr_q] : DW'(Zero);
  assign count     = count_q;

  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      unique case (xfer_kind(push, pop))
        XferPush: begin
          wr_ptr_d = wr_ptr_q + PTRW'(1);
          count_d  = count_q + (PTRW + 1)'(1);
        end
        XferPop: begin
          rd_ptr_d = rd_ptr_q + PTRW'(1);
          count_d  = count_q - (PTRW + 1)'(1);
        end
        XferBoth: begin
          wr_ptr_d = wr_ptr_q + PTRW'(1);
          rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; reads are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= in_pc;
      inst_mem_q[wr_ptr_q] <= in_inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: reset, ordering, full/back-pressure,
// streaming with wrap, flush and empty pass-through.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic [2:0]  count;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  inst_fetch_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_inst   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_count",    count,     0);
    chk("rst_outvalid", out_valid, 0);
    chk("rst_inready",  in_ready,  1);
    chk("rst_outpc",    out_pc,    0);
    chk("rst_outinst",  out_inst,  0);
    rst = 1'b0;

    // 1: asynchronous reset mid-operation
    push_one(32'h100, 32'hAAAA0001);
    push_one(32'h104, 32'hAAAA0002);
    chk("t1_count_pre", count, 2);
    chk("t1_head_pre",  out_pc, 32'h100);
    #3 rst = 1'b1;
    #1;
    chk("t1_async_count",    count,     0);
    chk("t1_async_outvalid", out_valid, 0);
    chk("t1_async_outpc",    out_pc,    0);
    chk("t1_async_inready",  in_ready,  1);
    #1 rst = 1'b0;
    tick();

    // 2: basic ordering
    push_one(32'h00, 32'h20080001);
    push_one(32'h04, 32'h20090002);
    chk("t2_count2",   count,     2);
    chk("t2_valid",    out_valid, 1);
    chk("t2_head_pc",  out_pc,    32'h00);
    chk("t2_head_ins", out_inst,  32'h20080001);
    out_ready = 1'b1;
    tick();
    chk("t2_pc1",    out_pc,   32'h04);
    chk("t2_ins1",   out_inst, 32'h20090002);
    chk("t2_count1", count,    1);
    tick();
    out_ready = 1'b0;
    chk("t2_count0", count,     0);
    chk("t2_empty",  out_valid, 0);
    chk("t2_pc0",    out_pc,    0);

    // 3: full and back-pressure
    do_reset();
    for (int i = 0; i < 4; i++) push_one(32'(4 * i), 32'h1000 + 32'(4 * i));
    chk("t3_full_count", count,    4);
    chk("t3_full_rdy",   in_ready, 0);
    chk("t3_full_head",  out_pc,   32'h00);
    in_valid = 1'b1;
    in_pc    = 32'h10;
    in_inst  = 32'h1010;
    tick();
    chk("t3_blocked_count", count,    4);
    chk("t3_blocked_rdy",   in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_pop_count", count,    3);
    chk("t3_pop_rdy",   in_ready, 1);
    chk("t3_pop_head",  out_pc,   32'h04);
    tick();
    in_valid = 1'b0;
    chk("t3_refill_count", count,    4);
    chk("t3_refill_rdy",   in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_pc",  out_pc,   32'h04 + 32'(4 * i));
      chk("t3_drain_ins", out_inst, 32'h1004 + 32'(4 * i));
      tick();
    end
    out_ready = 1'b0;
    chk("t3_drained", count, 0);

    // 4: simultaneous push/pop at count 2, pointers wrap twice
    push_one(32'h20, 32'h2020);
    push_one(32'h24, 32'h2024);
    chk("t4_count_pre", count, 2);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_pc   = 32'h28 + 32'(4 * k);
      in_inst = 32'h2028 + 32'(4 * k);
      chk("t4_stream_pc", out_pc, 32'h20 + 32'(4 * k));
      tick();
      chk("t4_stream_count", count, 2);
    end
    in_valid = 1'b0;
    chk("t4_tail_pc0", out_pc, 32'h40);
    tick();
    chk("t4_tail_pc1",  out_pc,   32'h44);
    chk("t4_tail_ins1", out_inst, 32'h2044);
    tick();
    out_ready = 1'b0;
    chk("t4_empty", count, 0);

    // 5: flush with push and pop pending
    push_one(32'h80, 32'h3080);
    push_one(32'h84, 32'h3084);
    push_one(32'h88, 32'h3088);
    chk("t5_count3", count, 3);
    in_valid  = 1'b1;
    in_pc     = 32'h8C;
    in_inst   = 32'h308C;
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t5_flush_count", count,     0);
    chk("t5_flush_valid", out_valid, 0);
    chk("t5_flush_pc",    out_pc,    0);
    chk("t5_flush_rdy",   in_ready,  1);
    push_one(32'h40, 32'h4040);
    chk("t5_target_valid", out_valid, 1);
    chk("t5_target_pc",    out_pc,    32'h40);
    chk("t5_target_ins",   out_inst,  32'h4040);
    chk("t5_target_count", count,     1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5_after_pop", count, 0);

    // 6: empty pass-through, one-cycle latency
    in_valid  = 1'b1;
    in_pc     = 32'h08;
    in_inst   = 32'h5008;
    out_ready = 1'b1;
    #1;
    chk("t6_no_bypass", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("t6_valid", out_valid, 1);
    chk("t6_pc",    out_pc,    32'h08);
    chk("t6_ins",   out_inst,  32'h5008);
    tick();
    out_ready = 1'b0;
    chk("t6_consumed_valid", out_valid, 0);
    chk("t6_consumed_count", count,     0);

    // Reset dominates a simultaneous flush
    push_one(32'hC0, 32'h60C0);
    flush = 1'b1;
    rst   = 1'b1;
    tick();
    chk("rf_count", count,     0);
    chk("rf_valid", out_valid, 0);
    flush = 1'b0;
    rst   = 1'b0;
    tick();
    chk("rf_after", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
